// File: rtl/ltu_pkg.sv
// Shared types, widths and helpers for the LTU clock monitor.
package ltu_pkg;

    localparam int RUN_W = 5;
    localparam int ERR_W = 8;

    localparam logic [RUN_W-1:0] RUN_MAX = 5'd31;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        CHECK = 2'd2,
        LOCK  = 2'd3
    } ltu_state_e;

    function automatic logic [RUN_W-1:0] ltu_exp_half(input logic [1:0] set);
        ltu_exp_half = 5'd1 << set;
    endfunction

    function automatic logic [ERR_W-1:0] ltu_err_inc(input logic [ERR_W-1:0] cnt);
        if (cnt == ERR_MAX) begin
            ltu_err_inc = cnt;
        end else begin
            ltu_err_inc = cnt + 8'd1;
        end
    endfunction

endpackage

// File: rtl/ltu_run_meter.sv
// Tick edge detector and half-period run counter; latches the length of
// each completed half-period.
module ltu_run_meter
    import ltu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             tick_i,
    output logic             edge_o,
    output logic [RUN_W-1:0] run_cnt_o,
    output logic [RUN_W-1:0] half_o
);

    logic             tick_prev_q;
    logic             valid_prev_q;
    logic [RUN_W-1:0] run_cnt_q;
    logic [RUN_W-1:0] run_cnt_d;
    logic [RUN_W-1:0] half_q;
    logic [RUN_W-1:0] half_d;
    logic             edge_s;

    assign edge_s = valid_i & valid_prev_q & (tick_i ^ tick_prev_q);

    // Next run length: cleared without valid, restarted at 1 on an edge, else saturating count.
    always_comb begin
        run_cnt_d = run_cnt_q;
        half_d    = half_q;
        if (!valid_i) begin
            run_cnt_d = '0;
        end else if (edge_s) begin
            half_d    = run_cnt_q;
            run_cnt_d = 5'd1;
        end else if (run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + 5'd1;
        end else begin
            run_cnt_d = run_cnt_q;
        end
    end

    // Input history and counter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_prev_q  <= 1'b0;
            valid_prev_q <= 1'b0;
            run_cnt_q    <= '0;
            half_q       <= '0;
        end else begin
            tick_prev_q  <= tick_i;
            valid_prev_q <= valid_i;
            run_cnt_q    <= run_cnt_d;
            half_q       <= half_d;
        end
    end

    assign edge_o    = edge_s;
    assign run_cnt_o = run_cnt_q;
    assign half_o    = half_q;

endmodule

// File: rtl/ltu_clk_mon.sv
// LTU clock monitor: converts divider ticks into rise/fall enables and tracks
// half-period conformance, lock status and a saturating error count.
module ltu_clk_mon
    import ltu_pkg::*;
#(
    parameter int LOCK_RUNS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       LTUCLKDIVSET,
    input  logic [1:0]       LTUCLKDIVGET,
    output logic             LTUCLKRISE,
    output logic             LTUCLKFALL,
    output logic             LTULOCK,
    output logic [ERR_W-1:0] LTUERRCNT,
    output logic [RUN_W-1:0] LTUHALF
);

    localparam logic [3:0] LOCK_RUNS_C = 4'(LOCK_RUNS);

    logic             valid_s;
    logic             tick_s;
    logic             edge_s;
    logic             set_chg_s;
    logic             match_s;
    logic             timeout_s;
    logic             strobe_en_s;
    logic [RUN_W-1:0] run_cnt_s;
    logic [RUN_W-1:0] exp_s;
    logic [3:0]       good_nxt_s;
    logic [ERR_W-1:0] err_inc_s;

    ltu_state_e       state_q;
    logic [3:0]       good_q;
    logic [ERR_W-1:0] err_q;
    logic [1:0]       set_q;
    logic             rise_q;
    logic             fall_q;
    logic             lock_q;

    assign valid_s = LTUCLKDIVGET[1];
    assign tick_s  = LTUCLKDIVGET[0];

    ltu_run_meter u_run_meter (
        .clk_i     (clk),
        .rst_i     (reset),
        .valid_i   (valid_s),
        .tick_i    (tick_s),
        .edge_o    (edge_s),
        .run_cnt_o (run_cnt_s),
        .half_o    (LTUHALF)
    );

    assign exp_s       = ltu_exp_half(LTUCLKDIVSET);
    assign set_chg_s   = (set_q != LTUCLKDIVSET);
    assign match_s     = (run_cnt_s == exp_s);
    // A full expected half-period without an edge means this one has overrun.
    assign timeout_s   = ~edge_s & (run_cnt_s == exp_s);
    assign strobe_en_s = (state_q != IDLE);
    assign good_nxt_s  = good_q + 4'd1;
    assign err_inc_s   = ltu_err_inc(err_q);

    // Monitor FSM with registered strobes, lock flag and error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            good_q  <= 4'd0;
            err_q   <= '0;
            set_q   <= 2'd0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            set_q  <= LTUCLKDIVSET;
            rise_q <= strobe_en_s & edge_s & tick_s;
            fall_q <= strobe_en_s & edge_s & ~tick_s;
            lock_q <= 1'b0;
            if (!valid_s) begin
                state_q <= IDLE;
                good_q  <= 4'd0;
            end else if (state_q == IDLE) begin
                state_q <= ALIGN;
                good_q  <= 4'd0;
            end else if (set_chg_s) begin
                state_q <= ALIGN;
                good_q  <= 4'd0;
            end else begin
                case (state_q)
                    ALIGN: begin
                        if (edge_s) begin
                            state_q <= CHECK;
                            good_q  <= 4'd0;
                        end else begin
                            state_q <= ALIGN;
                        end
                    end
                    CHECK: begin
                        if (timeout_s) begin
                            state_q <= ALIGN;
                            good_q  <= 4'd0;
                            err_q   <= err_inc_s;
                        end else if (edge_s && match_s && (good_nxt_s == LOCK_RUNS_C)) begin
                            state_q <= LOCK;
                            good_q  <= 4'd0;
                            lock_q  <= 1'b1;
                        end else if (edge_s && match_s) begin
                            good_q  <= good_nxt_s;
                        end else if (edge_s) begin
                            good_q  <= 4'd0;
                            err_q   <= err_inc_s;
                        end else begin
                            state_q <= CHECK;
                        end
                    end
                    LOCK: begin
                        if (timeout_s) begin
                            state_q <= ALIGN;
                            good_q  <= 4'd0;
                            err_q   <= err_inc_s;
                        end else if (edge_s && !match_s) begin
                            state_q <= CHECK;
                            good_q  <= 4'd0;
                            err_q   <= err_inc_s;
                        end else begin
                            state_q <= LOCK;
                            lock_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        good_q  <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign LTUCLKRISE = rise_q;
    assign LTUCLKFALL = fall_q;
    assign LTULOCK    = lock_q;
    assign LTUERRCNT  = err_q;

endmodule

// File: tb/tb_ltu_clk_mon.sv
// Self-checking bench for ltu_clk_mon: vector table plus multi-cycle sequences.
module tb_ltu_clk_mon;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] LTUCLKDIVSET;
    logic [1:0] LTUCLKDIVGET;
    logic       LTUCLKRISE;
    logic       LTUCLKFALL;
    logic       LTULOCK;
    logic [7:0] LTUERRCNT;
    logic [4:0] LTUHALF;

    int   checks = 0;
    int   errors = 0;
    logic pv = 1'b0;
    logic pt = 1'b0;
    bit   sb_en = 1'b0;

    typedef struct packed {
        logic [1:0] get;
        logic       rise;
        logic       fall;
        logic       lock;
        logic [7:0] err;
        logic [4:0] half;
    } vec_t;

    vec_t       tbl [17];
    vec_t       exp_q [$];
    logic [1:0] sb_q [$];

    always #5 clk = ~clk;

    ltu_clk_mon #(.LOCK_RUNS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .LTUCLKDIVSET (LTUCLKDIVSET),
        .LTUCLKDIVGET (LTUCLKDIVGET),
        .LTUCLKRISE   (LTUCLKRISE),
        .LTUCLKFALL   (LTUCLKFALL),
        .LTULOCK      (LTULOCK),
        .LTUERRCNT    (LTUERRCNT),
        .LTUHALF      (LTUHALF)
    );

    function automatic vec_t mk(input logic [1:0] g, input logic r, input logic f,
                                input logic l, input logic [7:0] e, input logic [4:0] h);
        vec_t v;
        v.get = g; v.rise = r; v.fall = f; v.lock = l; v.err = e; v.half = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // One clock: drive inputs, predict strobes from the tick history, compare after the edge.
    task automatic step(input logic v, input logic t, input logic [1:0] s);
        logic [1:0] e;
        LTUCLKDIVGET = {v, t};
        LTUCLKDIVSET = s;
        e[1] = v & pv & t & ~pt;
        e[0] = v & pv & ~t & pt;
        if (sb_en) sb_q.push_back(e);
        pv = v;
        pt = t;
        @(posedge clk);
        #1;
        if (sb_en) begin
            e = sb_q.pop_front();
            chk("strobes{rise,fall}", {LTUCLKRISE, LTUCLKFALL}, e);
        end
    endtask

    task automatic run(input logic t, input int len, input logic [1:0] s);
        for (int i = 0; i < len; i++) step(1'b1, t, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t cur;
        vec_t want;

        // SET = 00 throughout; expected outputs follow each sampled input.
        tbl[0]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        tbl[1]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        tbl[2]  = mk(2'b10, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
        tbl[3]  = mk(2'b11, 1'b1, 1'b0, 1'b0, 8'd0, 5'd1);
        tbl[4]  = mk(2'b10, 1'b0, 1'b1, 1'b0, 8'd0, 5'd1);
        tbl[5]  = mk(2'b11, 1'b1, 1'b0, 1'b0, 8'd0, 5'd1);
        tbl[6]  = mk(2'b10, 1'b0, 1'b1, 1'b0, 8'd0, 5'd1);
        tbl[7]  = mk(2'b11, 1'b1, 1'b0, 1'b1, 8'd0, 5'd1);
        tbl[8]  = mk(2'b10, 1'b0, 1'b1, 1'b1, 8'd0, 5'd1);
        tbl[9]  = mk(2'b11, 1'b1, 1'b0, 1'b1, 8'd0, 5'd1);
        tbl[10] = mk(2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 5'd1);
        tbl[11] = mk(2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 5'd1);
        tbl[12] = mk(2'b10, 1'b0, 1'b0, 1'b0, 8'd0, 5'd1);
        tbl[13] = mk(2'b10, 1'b0, 1'b0, 1'b0, 8'd0, 5'd1);
        tbl[14] = mk(2'b11, 1'b1, 1'b0, 1'b0, 8'd0, 5'd2);
        tbl[15] = mk(2'b11, 1'b0, 1'b0, 1'b0, 8'd1, 5'd2);
        tbl[16] = mk(2'b10, 1'b0, 1'b1, 1'b0, 8'd1, 5'd2);

        reset        = 1'b1;
        LTUCLKDIVGET = 2'b00;
        LTUCLKDIVSET = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {LTUCLKRISE, LTUCLKFALL, LTULOCK, LTUERRCNT, LTUHALF}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(tbl[i]);
            step(tbl[i].get[1], tbl[i].get[0], 2'b00);
            want = exp_q.pop_front();
            cur  = mk(tbl[i].get, LTUCLKRISE, LTUCLKFALL, LTULOCK, LTUERRCNT, LTUHALF);
            chk($sformatf("vec%0d_rise", i), cur.rise, want.rise);
            chk($sformatf("vec%0d_fall", i), cur.fall, want.fall);
            chk($sformatf("vec%0d_lock", i), cur.lock, want.lock);
            chk($sformatf("vec%0d_err", i),  cur.err,  want.err);
            chk($sformatf("vec%0d_half", i), cur.half, want.half);
        end

        sb_en = 1'b1;

        // Division 16: half-period 8, partial first run discarded.
        step(1'b0, 1'b0, 2'd3);
        step(1'b0, 1'b0, 2'd3);
        run(1'b0, 8, 2'd3);
        run(1'b1, 8, 2'd3);
        run(1'b0, 8, 2'd3);
        run(1'b1, 8, 2'd3);
        run(1'b0, 8, 2'd3);
        chk("set3_lock_before_4th", LTULOCK, 1'b0);
        step(1'b1, 1'b1, 2'd3);
        chk("set3_lock", LTULOCK, 1'b1);
        chk("set3_half", LTUHALF, 5'd8);
        chk("set3_err", LTUERRCNT, 8'd1);

        // Set change 11->01 while locked: realign without an error.
        step(1'b1, 1'b1, 2'd1);
        chk("setchg_lock", LTULOCK, 1'b0);
        chk("setchg_err", LTUERRCNT, 8'd1);
        run(1'b0, 2, 2'd1);
        run(1'b1, 2, 2'd1);
        run(1'b0, 2, 2'd1);
        run(1'b1, 2, 2'd1);
        run(1'b0, 2, 2'd1);
        chk("set1_lock", LTULOCK, 1'b1);
        chk("set1_half", LTUHALF, 5'd2);

        // Overlong high run of 3.
        run(1'b1, 3, 2'd1);
        chk("long_run_lock", LTULOCK, 1'b0);
        chk("long_run_err", LTUERRCNT, 8'd2);
        run(1'b0, 2, 2'd1);
        chk("long_run_half", LTUHALF, 5'd3);
        run(1'b1, 2, 2'd1);
        run(1'b0, 2, 2'd1);
        run(1'b1, 2, 2'd1);
        chk("relock_not_yet", LTULOCK, 1'b0);
        run(1'b0, 2, 2'd1);
        chk("relock", LTULOCK, 1'b1);

        // Set change 01->10, lock at half-period 4, then hold the tick.
        step(1'b1, 1'b0, 2'd2);
        chk("setchg2_lock", LTULOCK, 1'b0);
        chk("setchg2_err", LTUERRCNT, 8'd2);
        run(1'b1, 4, 2'd2);
        run(1'b0, 4, 2'd2);
        run(1'b1, 4, 2'd2);
        run(1'b0, 4, 2'd2);
        run(1'b1, 4, 2'd2);
        chk("set2_lock", LTULOCK, 1'b1);
        chk("set2_half", LTUHALF, 5'd4);
        step(1'b1, 1'b1, 2'd2);
        chk("timeout_lock", LTULOCK, 1'b0);
        chk("timeout_err", LTUERRCNT, 8'd3);
        run(1'b1, 10, 2'd2);
        chk("align_no_more_err", LTUERRCNT, 8'd3);
        chk("align_lock", LTULOCK, 1'b0);

        // Saturation: expect 8, toggle every cycle.
        step(1'b1, 1'b0, 2'd3);
        step(1'b1, 1'b1, 2'd3);
        for (int i = 0; i < 10; i++) step(1'b1, ~pt, 2'd3);
        chk("mismatch_err10", LTUERRCNT, 8'd13);
        chk("mismatch_half", LTUHALF, 5'd1);
        for (int i = 0; i < 300; i++) step(1'b1, ~pt, 2'd3);
        chk("err_saturated", LTUERRCNT, 8'd255);
        chk("sat_lock", LTULOCK, 1'b0);

        // Asynchronous reset mid-operation.
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {LTUCLKRISE, LTUCLKFALL, LTULOCK, LTUERRCNT, LTUHALF}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pv = 1'b0;
        pt = 1'b0;
        step(1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0);
        chk("post_reset_outputs", {LTULOCK, LTUERRCNT, LTUHALF}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
